// File: rtl/ctl_pkg.sv
// Shared state codes and widths for the set/count timer control FSM.
// Latency: n/a (types only). Backpressure: n/a.
// PAUSE is only reachable when CTL_PAUSE_EN is defined; otherwise its code is illegal.
package ctl_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 4'd0,
        SET_MIN = 4'd1,
        SET_SEC = 4'd2,
        RUN     = 4'd3,
        PAUSE   = 4'd4
    } state_e;

endpackage

// File: rtl/ctl.sv
// Main control FSM for the set/count timer: idle, set-minutes, set-seconds, run.
// Latency: one registered state; Moore decodes plus combinational inc/dec, no output delay.
// Backpressure: none; optional CTL_PAUSE_EN adds a PAUSE state entered from RUN on trig.
module ctl #(
    parameter int STATE_W = ctl_pkg::STATE_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               trig,
    input  logic               set,
    input  logic               up,
    input  logic               down,
    input  logic               complete,
    output logic               init_regs,
    output logic               count_enabled,
    output logic               inc,
    output logic               dec,
    output logic               min,
    output logic [STATE_W-1:0] state
);
    import ctl_pkg::*;

    state_e state_q;
    state_e state_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (set) state_d = SET_MIN;
            end
            SET_MIN: begin
                if (trig)     state_d = RUN;
                else if (set) state_d = SET_SEC;
            end
            SET_SEC: begin
                if (trig)     state_d = RUN;
                else if (set) state_d = SET_MIN;
            end
            RUN: begin
                // complete outranks trig so a finishing countdown always clears the datapath
                if (complete) state_d = IDLE;
`ifdef CTL_PAUSE_EN
                else if (trig) state_d = PAUSE;
`else
                else if (trig) state_d = SET_MIN;
`endif
            end
`ifdef CTL_PAUSE_EN
            PAUSE: begin
                if (trig)     state_d = RUN;
                else if (set) state_d = SET_SEC;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        init_regs     = 1'b0;
        count_enabled = 1'b0;
        inc           = 1'b0;
        dec           = 1'b0;
        min           = 1'b0;
        case (state_q)
            IDLE: init_regs = 1'b1;
            SET_MIN: begin
                min = 1'b1;
                inc = up & ~down;
                dec = down & ~up;
            end
            SET_SEC: begin
                inc = up & ~down;
                dec = down & ~up;
            end
            RUN: count_enabled = 1'b1;
`ifdef CTL_PAUSE_EN
            PAUSE: begin
                min = 1'b1;
                inc = up & ~down;
                dec = down & ~up;
            end
`endif
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_ctl.sv
// Directed plus randomized check of ctl against a rule-level mode model.
module tb_ctl;

    logic       clk = 1'b0;
    logic       reset;
    logic       trig, set, up, down, complete;
    logic       init_regs, count_enabled, inc, dec, min;
    logic [3:0] state;

    int errors = 0;
    int checks = 0;
    int mst    = 0;

    ctl dut (
        .clk          (clk),
        .reset        (reset),
        .trig         (trig),
        .set          (set),
        .up           (up),
        .down         (down),
        .complete     (complete),
        .init_regs    (init_regs),
        .count_enabled(count_enabled),
        .inc          (inc),
        .dec          (dec),
        .min          (min),
        .state        (state)
    );

    always #5 clk = ~clk;

    wire [8:0] obs = {init_regs, count_enabled, inc, dec, min, state};

    // Expected {init_regs, count_enabled, inc, dec, min, state} for a mode and button levels.
    function automatic logic [8:0] exp_out(int m, logic u, logic d);
        logic [3:0] code;
        logic       i_r, ce, in_c, de_c, mn;
        code = m[3:0];
        i_r = 0; ce = 0; in_c = 0; de_c = 0; mn = 0;
        if (m == 0) i_r = 1;
        if (m == 3) ce = 1;
        if (m == 1 || m == 4) mn = 1;
        if (m == 1 || m == 2 || m == 4) begin
            in_c = u && !d;
            de_c = d && !u;
        end
        return {i_r, ce, in_c, de_c, mn, code};
    endfunction

    function automatic int nxt(int m, logic t, logic s, logic c);
        if (m == 0) return s ? 1 : 0;
        if (m == 1) return t ? 3 : (s ? 2 : 1);
        if (m == 2) return t ? 3 : (s ? 1 : 2);
        if (m == 3) begin
            if (c) return 0;
`ifdef CTL_PAUSE_EN
            if (t) return 4;
`else
            if (t) return 1;
`endif
            return 3;
        end
`ifdef CTL_PAUSE_EN
        if (m == 4) return t ? 3 : (s ? 2 : 4);
`endif
        return 0;
    endfunction

    task automatic check(string tag, logic [8:0] o, logic [8:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic step(string tag, logic t, logic s, logic u, logic d, logic c);
        @(negedge clk);
        trig = t; set = s; up = u; down = d; complete = c;
        #1 check(tag, obs, exp_out(mst, u, d));
        @(posedge clk);
        mst = nxt(mst, t, s, c);
    endtask

    initial begin
        reset = 1'b0;
        trig = 0; set = 0; up = 0; down = 0; complete = 0;
        #12 check("reset_state", obs, exp_out(0, 1'b0, 1'b0));
        @(negedge clk) reset = 1'b1;

        //     tag            trig set up down cmpl
        step("idle_ignore",   1,   0,  1, 0,   1);
        step("idle_set",      0,   1,  0, 0,   0);
        step("setmin_up",     0,   0,  1, 0,   0);
        step("setmin_down",   0,   0,  0, 1,   0);
        step("setmin_toggle", 0,   1,  0, 0,   0);
        step("setsec_up",     0,   0,  1, 0,   0);
        step("setsec_both",   0,   0,  1, 1,   0);
        step("setsec_toggle", 0,   1,  0, 0,   0);
        step("setmin_trig",   1,   0,  0, 0,   0);
        step("run_hold_up1",  0,   1,  1, 0,   0);
        step("run_hold_up2",  0,   0,  1, 0,   0);
        step("run_trig",      1,   0,  1, 0,   0);
        step("after_stop",    0,   0,  1, 0,   0);
        step("rerun",         1,   0,  0, 0,   0);
        step("run_complete",  0,   0,  0, 0,   1);
        step("idle_cmpl_hld", 0,   0,  0, 0,   1);
        step("to_setmin",     0,   1,  0, 0,   1);
        step("setmin_cmpl",   1,   0,  0, 0,   1);
        step("run_cmpl_trig", 1,   0,  0, 0,   1);
        step("idle_again",    0,   1,  0, 0,   0);
        step("to_run",        1,   0,  0, 0,   0);
        step("in_run",        0,   0,  0, 0,   0);

        // Asynchronous reset between clock edges while running.
        @(negedge clk);
        #2 reset = 1'b0;
        mst = 0;
        #1 check("async_reset", obs, exp_out(0, 1'b0, 1'b0));
        @(negedge clk) reset = 1'b1;
        step("post_reset", 0, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            step("random",
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0));
        end
        step("final", 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
